dbus_sram_ctrl: RTL

Data-bus controller that sits directly downstream of the `naive_mips` data port: it receives `dbus_*` requests and drives one 32-bit asynchronous SRAM bank (two 16-bit chips sharing address/control) with a programmable access time. It holds `dbus_stall` high until the access completes, so the CPU MEM stage freezes with its request held. This replaces the zero-wait behavioural memory used on the basic bench.

---
 rtl/dbus_sram_ctrl_pkg.sv | 34 +++
 rtl/dbus_sram_ctrl_wait_timer.sv | 51 +++++
 rtl/dbus_sram_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dbus_sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dbus_sram_ctrl_pkg
// Shared types and constants for the dbus -> asynchronous SRAM controller.
//   sram_state_t    : controller FSM states (IDLE / ACCESS / DONE)
//   SRAM_CNT_W      : width of the access-time counter
//   SRAM_WAIT_MAX   : largest programmable strobe length in cycles
//   sram_wait_clamp : folds a WAIT_CYCLES parameter into the legal 1..15 range
// -----------------------------------------------------------------------------
package dbus_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    SRAM_IDLE   = 2'd0,
    SRAM_ACCESS = 2'd1,
    SRAM_DONE   = 2'd2
  } sram_state_t;

  localparam int SRAM_CNT_W    = 4;
  localparam int SRAM_WAIT_MAX = 15;

  // An out-of-range strobe length would make the counter wrap or never expire,
  // so the parameter is saturated into 1..SRAM_WAIT_MAX at elaboration.
  function automatic logic [SRAM_CNT_W-1:0] sram_wait_clamp(input int cycles);
    logic [SRAM_CNT_W-1:0] v;
    if (cycles < 32'sd1) begin
      v = SRAM_CNT_W'(1);
    end else if (cycles > SRAM_WAIT_MAX) begin
      v = SRAM_CNT_W'(SRAM_WAIT_MAX);
    end else begin
      v = SRAM_CNT_W'(cycles);
    end
    return v;
  endfunction

endpackage

// File: rtl/dbus_sram_ctrl_wait_timer.sv
// -----------------------------------------------------------------------------
// sram_wait_timer
// Load/decrement counter timing how long the SRAM strobe stays asserted.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   load      : load load_val into the counter (has priority over dec)
//   load_val  : strobe length in cycles
//   dec       : decrement by one (saturates at zero)
//   cnt       : current count
//   last      : high while cnt == 1, i.e. the final strobe cycle
// -----------------------------------------------------------------------------
module sram_wait_timer
  import dbus_sram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [SRAM_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic [SRAM_CNT_W-1:0] cnt,
  output logic                  last
);

  logic [SRAM_CNT_W-1:0] cnt_d;
  logic [SRAM_CNT_W-1:0] cnt_q;

  // Next-count selection: load wins, otherwise count down without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != SRAM_CNT_W'(0))) begin
      cnt_d = cnt_q - SRAM_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= SRAM_CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == SRAM_CNT_W'(1));

endmodule

// File: rtl/dbus_sram_ctrl.sv
// -----------------------------------------------------------------------------
// dbus_sram_ctrl
// Bridges the naive_mips dbus data port to one 32-bit asynchronous SRAM bank
// (two 16-bit chips sharing address/control) with a programmable strobe time.
// dbus_stall holds the CPU MEM stage until the access completes.
//
// Parameters:
//   ADDR_W      : SRAM word-address width, sram_addr = dbus_address[ADDR_W+1:2]
//   WAIT_CYCLES : cycles the SRAM strobe is held (1..15)
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   dbus_address/byteenable/read/write/wrdata : CPU request, held while stalled
//   dbus_rddata            : registered read data, held until the next read
//   dbus_stall             : combinational stall back to the CPU
//   sram_addr, sram_be_n   : registered word address / active-low byte lanes
//   sram_ce_n/oe_n/we_n    : registered active-low strobes
//   sram_dq_o, sram_dq_oe  : registered write data and pad drive enable
//   sram_dq_i              : pad read data
//
// Build option:
//   DBUS_SRAM_CTRL_POSTED_WRITE_EN - when defined, a write accepted in IDLE is
//   posted (no stall); any request that arrives while it is still in flight
//   stalls until the controller is back in IDLE. When undefined, every write
//   blocks exactly like a read.
// -----------------------------------------------------------------------------
module dbus_sram_ctrl
  import dbus_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dbus_address,
  input  logic [3:0]        dbus_byteenable,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [31:0]       dbus_wrdata,
  output logic [31:0]       dbus_rddata,
  output logic              dbus_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i
);

  localparam logic [SRAM_CNT_W-1:0] WAIT_LOAD = sram_wait_clamp(WAIT_CYCLES);

  sram_state_t           state_d,   state_q;
  logic                  is_wr_d,   is_wr_q;
  logic                  posted_d,  posted_q;
  logic [ADDR_W-1:0]     addr_d,    addr_q;
  logic [3:0]            be_n_d,    be_n_q;
  logic [31:0]           dq_o_d,    dq_o_q;
  logic [31:0]           rddata_d,  rddata_q;
  logic                  ce_n_d,    ce_n_q;
  logic                  oe_n_d,    oe_n_q;
  logic                  we_n_d,    we_n_q;
  logic                  dq_oe_d,   dq_oe_q;

  logic                  req_s;
  logic                  timer_load_s;
  logic                  timer_dec_s;
  logic                  timer_last_s;
  logic [SRAM_CNT_W-1:0] timer_cnt_s;
  logic                  unused_s;

  assign req_s = dbus_read | dbus_write;

  // Address bits outside the SRAM word range and the raw count are not needed.
  assign unused_s = ^{dbus_address[31:ADDR_W+2], dbus_address[1:0], timer_cnt_s};

  sram_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .load_val (WAIT_LOAD),
    .dec      (timer_dec_s),
    .cnt      (timer_cnt_s),
    .last     (timer_last_s)
  );

  // FSM next state plus capture of the request and of the read data.
  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    posted_d     = posted_q;
    addr_d       = addr_q;
    be_n_d       = be_n_q;
    dq_o_d       = dq_o_q;
    rddata_d     = rddata_q;
    timer_load_s = 1'b0;
    timer_dec_s  = 1'b0;
    case (state_q)
      SRAM_IDLE: begin
        if (req_s) begin
          // Write wins when both request lines are high.
          is_wr_d      = dbus_write;
          addr_d       = dbus_address[ADDR_W+1:2];
          be_n_d       = ~dbus_byteenable;
          dq_o_d       = dbus_wrdata;
          timer_load_s = 1'b1;
          state_d      = SRAM_ACCESS;
`ifdef DBUS_SRAM_CTRL_POSTED_WRITE_EN
          posted_d     = dbus_write;
`else
          posted_d     = 1'b0;
`endif
        end else begin
          state_d = SRAM_IDLE;
        end
      end
      SRAM_ACCESS: begin
        timer_dec_s = 1'b1;
        if (timer_last_s) begin
          state_d = SRAM_DONE;
          // Sample the pads on the final strobe edge while OE is still low.
          if (!is_wr_q) begin
            rddata_d = sram_dq_i;
          end else begin
            rddata_d = rddata_q;
          end
        end else begin
          state_d = SRAM_ACCESS;
        end
      end
      SRAM_DONE: begin
        state_d  = SRAM_IDLE;
        posted_d = 1'b0;
      end
      default: begin
        state_d  = SRAM_IDLE;
        posted_d = 1'b0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they come straight off flops.
  always_comb begin
    ce_n_d  = ~(state_d == SRAM_ACCESS);
    oe_n_d  = ~((state_d == SRAM_ACCESS) & ~is_wr_d);
    we_n_d  = ~((state_d == SRAM_ACCESS) &  is_wr_d);
    dq_oe_d =  (state_d == SRAM_ACCESS) &  is_wr_d;
  end

  // State, request capture and pad registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SRAM_IDLE;
      is_wr_q  <= 1'b0;
      posted_q <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      be_n_q   <= 4'hF;
      dq_o_q   <= 32'h0000_0000;
      rddata_q <= 32'h0000_0000;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      posted_q <= posted_d;
      addr_q   <= addr_d;
      be_n_q   <= be_n_d;
      dq_o_q   <= dq_o_d;
      rddata_q <= rddata_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  // Stall releases in DONE of a blocking access; a posted write in flight
  // keeps DONE stalled for whatever request follows it.
`ifdef DBUS_SRAM_CTRL_POSTED_WRITE_EN
  assign dbus_stall = req_s
                    & ~((state_q == SRAM_DONE) & ~posted_q)
                    & ~((state_q == SRAM_IDLE) & dbus_write);
`else
  assign dbus_stall = req_s & ~((state_q == SRAM_DONE) & ~posted_q);
`endif

  assign dbus_rddata = rddata_q;
  assign sram_addr   = addr_q;
  assign sram_be_n   = be_n_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_oe  = dq_oe_q;

endmodule
